// File: rtl/axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_rr_arbiter
//
// Round-robin arbiter that shares one AXI4-Stream sink between NUM_CH
// AXI4-Stream sources. A grant is held for a burst of 2^min(log_burst,16)
// beats, so each source's samples leave in contiguous blocks. Every output
// beat is tagged on tuser with the channel it came from. The output stage is
// a single register slice that drives the downstream throttler directly.
//
// Optional feature macro: AXIS_RR_ARBITER_TLAST_EN
//   Defined   : adds M_AXIS_tlast, high on the final beat of each burst
//               (and on the held beat when a burst is cut short).
//   Undefined : no tlast port; bursts are delimited by tuser only.
//
// Ports
//   aclk            clock, all logic on the rising edge
//   areset          synchronous active-high reset
//   log_burst       burst length exponent, sampled when a grant is made
//   ch_enable       per-channel enable; disabled channels are never granted
//   S_AXIS_tvalid   source valid, bit i = channel i
//   S_AXIS_tdata    source data, slice i = channel i
//   S_AXIS_tready   source ready, at most one bit set
//   M_AXIS_tvalid   output valid (registered)
//   M_AXIS_tdata    output data (registered)
//   M_AXIS_tuser    source channel of the current output beat (registered)
//   M_AXIS_tlast    end-of-burst flag (registered, optional)
//   M_AXIS_tready   sink ready
// ---------------------------------------------------------------------------
module axis_rr_arbiter #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int NUM_CH           = 4,
    parameter int CH_WIDTH         = $clog2(NUM_CH)
) (
    input  logic                               aclk,
    input  logic                               areset,
    input  logic [4:0]                         log_burst,
    input  logic [NUM_CH-1:0]                  ch_enable,
    input  logic [NUM_CH-1:0]                  S_AXIS_tvalid,
    input  logic [NUM_CH*AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic [NUM_CH-1:0]                  S_AXIS_tready,
    output logic                               M_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0]        M_AXIS_tdata,
    output logic [CH_WIDTH-1:0]                M_AXIS_tuser,
`ifdef AXIS_RR_ARBITER_TLAST_EN
    output logic                               M_AXIS_tlast,
`endif
    input  logic                               M_AXIS_tready
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                      state_r;
    logic [CH_WIDTH-1:0]         gnt_r;
    logic [CH_WIDTH-1:0]         last_r;
    logic [16:0]                 beats_r;

    logic [NUM_CH-1:0]           cand_s;
    logic                        cand_any_s;
    logic [CH_WIDTH-1:0]         pick_s;
    logic                        pick_found_s;
    logic [CH_WIDTH-1:0]         idx_s;
    logic [4:0]                  lb_clamp_s;
    logic [16:0]                 burst_len_s;
    logic                        gnt_en_s;
    logic                        gnt_valid_s;
    logic                        out_free_s;
    logic                        gnt_ready_s;
    logic                        xfer_s;
    logic                        starve_s;
    logic                        drop_s;
    logic [AXIS_TDATA_WIDTH-1:0] sel_data_s;

    // Request qualification and burst length clamp.
    always_comb begin
        cand_s      = S_AXIS_tvalid & ch_enable;
        cand_any_s  = |cand_s;
        lb_clamp_s  = (log_burst > 5'd16) ? 5'd16 : log_burst;
        burst_len_s = 17'd1 << lb_clamp_s;
    end

    // Round-robin search: first candidate after last_r, wrapping modulo NUM_CH.
    always_comb begin
        pick_s       = '0;
        pick_found_s = 1'b0;
        idx_s        = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx_s = CH_WIDTH'((int'(last_r) + k) % NUM_CH);
            if (!pick_found_s && cand_s[idx_s]) begin
                pick_s       = idx_s;
                pick_found_s = 1'b1;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Data mux for the granted channel.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_r == CH_WIDTH'(i)) begin
                sel_data_s = S_AXIS_tdata[i*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Grant-side handshake. A disabled grant is cut the same cycle, and the
    // source is never acknowledged while reset is asserted.
    always_comb begin
        gnt_en_s    = ch_enable[gnt_r];
        gnt_valid_s = S_AXIS_tvalid[gnt_r];
        out_free_s  = !M_AXIS_tvalid || M_AXIS_tready;
        drop_s      = (state_r == ST_GRANT) && !gnt_en_s;
        gnt_ready_s = (state_r == ST_GRANT) && gnt_en_s && out_free_s && !areset;
        xfer_s      = gnt_ready_s && gnt_valid_s;
        starve_s    = gnt_ready_s && !gnt_valid_s;
        if (gnt_ready_s) begin
            S_AXIS_tready = {{(NUM_CH-1){1'b0}}, 1'b1} << gnt_r;
        end else begin
            S_AXIS_tready = '0;
        end
    end

    // Arbitration FSM and registered output slice.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r       <= ST_IDLE;
            gnt_r         <= '0;
            last_r        <= CH_WIDTH'(NUM_CH - 1);
            beats_r       <= 17'd0;
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tdata  <= '0;
            M_AXIS_tuser  <= '0;
`ifdef AXIS_RR_ARBITER_TLAST_EN
            M_AXIS_tlast  <= 1'b0;
`endif
        end else begin
            if (xfer_s) begin
                M_AXIS_tvalid <= 1'b1;
                M_AXIS_tdata  <= sel_data_s;
                M_AXIS_tuser  <= gnt_r;
            end else if (M_AXIS_tvalid && M_AXIS_tready) begin
                M_AXIS_tvalid <= 1'b0;
            end else begin
                M_AXIS_tvalid <= M_AXIS_tvalid;
            end

`ifdef AXIS_RR_ARBITER_TLAST_EN
            // An early release can only mark a beat that is still waiting
            // in the output register; an already-accepted beat is gone.
            if (xfer_s) begin
                M_AXIS_tlast <= (beats_r == 17'd1);
            end else if ((drop_s || starve_s) && M_AXIS_tvalid && !M_AXIS_tready) begin
                M_AXIS_tlast <= 1'b1;
            end else begin
                M_AXIS_tlast <= M_AXIS_tlast;
            end
`endif

            case (state_r)
                ST_IDLE: begin
                    if (cand_any_s) begin
                        gnt_r   <= pick_s;
                        last_r  <= pick_s;
                        beats_r <= burst_len_s;
                        state_r <= ST_GRANT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (drop_s) begin
                        state_r <= ST_IDLE;
                    end else if (xfer_s) begin
                        beats_r <= beats_r - 17'd1;
                        if (beats_r == 17'd1) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_GRANT;
                        end
                    end else if (starve_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_GRANT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: directed scenarios with literal
// expectations plus a long randomized run, all checked every cycle against a
// behavioural model of the arbitration rules.
module tb_axis_rr_arbiter;

    localparam int NCH = 4;
    localparam int W   = 32;

    logic              aclk;
    logic              areset;
    logic [4:0]        log_burst;
    logic [NCH-1:0]    ch_enable;
    logic [NCH-1:0]    S_AXIS_tvalid;
    logic [NCH*W-1:0]  S_AXIS_tdata;
    logic [NCH-1:0]    S_AXIS_tready;
    logic              M_AXIS_tvalid;
    logic [W-1:0]      M_AXIS_tdata;
    logic [1:0]        M_AXIS_tuser;
    logic              M_AXIS_tready;
`ifdef AXIS_RR_ARBITER_TLAST_EN
    logic              M_AXIS_tlast;
`endif

    axis_rr_arbiter #(.AXIS_TDATA_WIDTH(W), .NUM_CH(NCH)) dut (
        .aclk(aclk),
        .areset(areset),
        .log_burst(log_burst),
        .ch_enable(ch_enable),
        .S_AXIS_tvalid(S_AXIS_tvalid),
        .S_AXIS_tdata(S_AXIS_tdata),
        .S_AXIS_tready(S_AXIS_tready),
        .M_AXIS_tvalid(M_AXIS_tvalid),
        .M_AXIS_tdata(M_AXIS_tdata),
        .M_AXIS_tuser(M_AXIS_tuser),
`ifdef AXIS_RR_ARBITER_TLAST_EN
        .M_AXIS_tlast(M_AXIS_tlast),
`endif
        .M_AXIS_tready(M_AXIS_tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // per-source sample counters; channel i sends (i<<24) + cnt[i]
    int cnt [NCH];
    logic [NCH-1:0] hs;

    // beats seen leaving M
    int cap_d[$];
    int cap_u[$];
    int cap_l[$];
    int cap_t[$];

    // behavioural model: who holds the grant, how many beats remain
    bit md_busy;
    int md_ch, md_left, md_last;
    bit ov, ol;
    int od, ou;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NCH-1:0] exp_ready();
        logic [NCH-1:0] v;
        v = '0;
        if (md_busy && ch_enable[md_ch] && !areset && (!ov || M_AXIS_tready))
            v[md_ch] = 1'b1;
        return v;
    endfunction

    task automatic model_step();
        bit rdy, xfer, dis;
        int c, lbc;
        if (areset) begin
            md_busy = 0; md_ch = 0; md_left = 0; md_last = NCH - 1;
            ov = 0; od = 0; ou = 0; ol = 0;
        end else begin
            rdy  = (exp_ready() != '0);
            xfer = rdy && S_AXIS_tvalid[md_ch];
            dis  = md_busy && !ch_enable[md_ch];
            if (xfer) begin
                ov = 1; od = int'(S_AXIS_tdata[md_ch*W +: W]); ou = md_ch; ol = (md_left == 1);
            end else begin
                if (dis && ov && !M_AXIS_tready) ol = 1;
                if (ov && M_AXIS_tready) ov = 0;
            end
            if (!md_busy) begin
                for (int k = 1; k <= NCH; k++) begin
                    c = (md_last + k) % NCH;
                    if (!md_busy && S_AXIS_tvalid[c] && ch_enable[c]) begin
                        md_busy = 1; md_ch = c; md_last = c;
                        lbc = (int'(log_burst) > 16) ? 16 : int'(log_burst);
                        md_left = 1 << lbc;
                    end
                end
            end else if (dis) begin
                md_busy = 0;
            end else if (xfer) begin
                md_left--;
                if (md_left == 0) md_busy = 0;
            end else if (rdy) begin
                md_busy = 0;
            end
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < NCH; i++)
            S_AXIS_tdata[i*W +: W] = (i << 24) + cnt[i];
    endtask

    // One clock: compare on the falling edge, advance model on the rising edge.
    task automatic cycle();
        @(negedge aclk);
        chk("s_tready", S_AXIS_tready, exp_ready());
        chk("m_tvalid", M_AXIS_tvalid, ov);
        if (ov) begin
            chk("m_tdata", M_AXIS_tdata, od);
            chk("m_tuser", M_AXIS_tuser, ou);
`ifdef AXIS_RR_ARBITER_TLAST_EN
            chk("m_tlast", M_AXIS_tlast, ol);
`endif
        end
        if (M_AXIS_tvalid && M_AXIS_tready) begin
            cap_d.push_back(int'(M_AXIS_tdata));
            cap_u.push_back(int'(M_AXIS_tuser));
`ifdef AXIS_RR_ARBITER_TLAST_EN
            cap_l.push_back(int'(M_AXIS_tlast));
`else
            cap_l.push_back(0);
`endif
            cap_t.push_back(cyc);
        end
        hs = S_AXIS_tvalid & S_AXIS_tready;
        @(posedge aclk);
        model_step();
        #1;
        cyc++;
        for (int i = 0; i < NCH; i++) if (hs[i]) cnt[i]++;
        drive_data();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_caps();
        cap_d.delete(); cap_u.delete(); cap_l.delete(); cap_t.delete();
    endtask

    task automatic do_reset();
        S_AXIS_tvalid = '0;
        for (int i = 0; i < NCH; i++) cnt[i] = 0;
        drive_data();
        areset = 1'b1;
        cycle();
        areset = 1'b0;
    endtask

    int tu2 [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    bit done;
    int n0;

    initial begin
        areset = 1'b1; log_burst = 5'd0; ch_enable = '0; S_AXIS_tvalid = '0;
        M_AXIS_tready = 1'b1;
        for (int i = 0; i < NCH; i++) cnt[i] = 0;
        drive_data();
        run(2);
        areset = 1'b0;
        #3;
        chk("rst_tvalid", M_AXIS_tvalid, 0);
        chk("rst_tready", S_AXIS_tready, 0);
        chk("rst_tdata", M_AXIS_tdata, 0);
        chk("rst_tuser", M_AXIS_tuser, 0);

        // T1: single channel, bursts of 4 back-to-back with one idle cycle
        do_reset();
        ch_enable = 4'b0001; log_burst = 5'd2; M_AXIS_tready = 1'b1;
        cnt[0] = 2; drive_data();
        S_AXIS_tvalid = 4'b0001;
        clear_caps();
        run(14);
        chk("t1_count", cap_d.size() >= 8, 1);
        if (cap_d.size() >= 8) begin
            for (int j = 0; j < 8; j++) begin
                chk("t1_data", cap_d[j], 2 + j);
                chk("t1_user", cap_u[j], 0);
`ifdef AXIS_RR_ARBITER_TLAST_EN
                chk("t1_last", cap_l[j], (j % 4 == 3) ? 1 : 0);
`endif
            end
            chk("t1_dense", cap_t[3] - cap_t[0], 3);
            chk("t1_gap", cap_t[4] - cap_t[3], 2);
        end

        // T2: all channels, bursts of 2
        do_reset();
        ch_enable = 4'b1111; log_burst = 5'd1; M_AXIS_tready = 1'b1;
        S_AXIS_tvalid = 4'b1111;
        clear_caps();
        run(18);
        chk("t2_count", cap_u.size() >= 10, 1);
        if (cap_u.size() >= 10)
            for (int j = 0; j < 10; j++) chk("t2_user", cap_u[j], tu2[j]);

        // T3: ch1, burst of 8, sink stalls mid-burst
        do_reset();
        ch_enable = 4'b0010; log_burst = 5'd3; M_AXIS_tready = 1'b1;
        S_AXIS_tvalid = 4'b0010;
        clear_caps();
        run(4);
        M_AXIS_tready = 1'b0;
        run(5);
        M_AXIS_tready = 1'b1;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            cycle();
            if (cnt[1] >= 8) begin
                S_AXIS_tvalid = '0;
                done = 1;
            end
        end
        chk("t3_done", done, 1);
        run(4);
        chk("t3_count", cap_d.size(), 8);
        for (int j = 0; j < cap_d.size() && j < 8; j++) begin
            chk("t3_data", cap_d[j], 32'h0100_0000 + j);
            chk("t3_user", cap_u[j], 1);
        end

        // T4: disable ch0 after 3 beats, ch2 takes over
        do_reset();
        ch_enable = 4'b0101; log_burst = 5'd4; M_AXIS_tready = 1'b1;
        S_AXIS_tvalid = 4'b0101;
        clear_caps();
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle();
            if (cnt[0] >= 3) done = 1;
        end
        chk("t4_done", done, 1);
        ch_enable = 4'b0100;
        run(20);
        chk("t4_count", cap_u.size() >= 4, 1);
        if (cap_u.size() >= 4) begin
            chk("t4_u0", cap_u[2], 0);
            chk("t4_u3", cap_u[3], 2);
            chk("t4_gap", cap_t[3] - cap_t[2], 3);
        end
        n0 = 0;
        foreach (cap_u[j]) if (cap_u[j] == 0) n0++;
        chk("t4_ch0_beats", n0, 3);

        // T5: reset mid-burst with the output stalled
        do_reset();
        ch_enable = 4'b0011; log_burst = 5'd2; M_AXIS_tready = 1'b1;
        S_AXIS_tvalid = 4'b0011;
        done = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            cycle();
            if (cnt[1] >= 2) done = 1;
        end
        chk("t5_done", done, 1);
        M_AXIS_tready = 1'b0;
        run(2);
        areset = 1'b1;
        cycle();
        areset = 1'b0;
        #3;
        chk("t5_tvalid", M_AXIS_tvalid, 0);
        chk("t5_tready", S_AXIS_tready, 0);
        M_AXIS_tready = 1'b1;
        clear_caps();
        run(6);
        chk("t5_count", cap_u.size() >= 1, 1);
        if (cap_u.size() >= 1) chk("t5_first", cap_u[0], 0);

        // Random: valid, sink ready, enables, burst length, rare resets
        do_reset();
        ch_enable = 4'b1111; log_burst = 5'd1;
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < NCH; c++) S_AXIS_tvalid[c] = ($urandom_range(0, 9) < 7);
            M_AXIS_tready = ($urandom_range(0, 3) != 0);
            if (i % 40 == 0) begin
                ch_enable = 4'($urandom_range(0, 15));
                log_burst = ($urandom_range(0, 9) == 0) ? 5'd20 : 5'($urandom_range(0, 3));
            end
            areset = ($urandom_range(0, 499) == 0);
            cycle();
        end
        areset = 1'b0;
        run(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Round-robin arbiter that shares one AXI4-Stream sink (throttler / DMA path) between NUM_CH AXI4-Stream sources. Grants are held for bursts of 2^log_burst beats so each source's samples leave in contiguous blocks. Every output beat is tagged with its source channel. The arbiter sits upstream of the stream throttler in the acquisition datapath, and its registered output stage drives the throttler's slave port directly.

## Interface
- AXIS_TDATA_WIDTH, 32, data width per channel
- NUM_CH, 4, number of source channels (2..8)
- CH_WIDTH, $clog2(NUM_CH), channel tag width
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  reset, synchronous, active-high
- log_burst  in  5  beats per grant = 2^min(log_burst,16), sampled at grant
- ch_enable  in  NUM_CH  per-channel enable; disabled channels are never granted
- S_AXIS_tvalid  in  NUM_CH  source valid, bit i = channel i
- S_AXIS_tdata  in  NUM_CH*AXIS_TDATA_WIDTH  source data, slice i = channel i
- S_AXIS_tready  out  NUM_CH  source ready, at most one bit set
- M_AXIS_tvalid  out  1  output valid (registered)
- M_AXIS_tdata  out  AXIS_TDATA_WIDTH  output data (registered)
- M_AXIS_tuser  out  CH_WIDTH  channel of current output beat (registered)
- M_AXIS_tready  in  1  sink ready

## Operation
- FSM states: IDLE, GRANT. Registers: state, gnt (CH_WIDTH), last (CH_WIDTH), beats (17 bits), output register.
- IDLE: candidates = S_AXIS_tvalid & ch_enable. If any candidate exists, pick the first set bit searching last+1, last+2, … modulo NUM_CH. Set gnt to it and last to it, load beats = 2^min(log_burst,16), then go to GRANT. If none, stay in IDLE.
- GRANT: S_AXIS_tready[gnt] = !M_AXIS_tvalid || M_AXIS_tready. All other tready bits are 0. In IDLE, all tready bits are 0.
- Transfer = S_AXIS_tvalid[gnt] && S_AXIS_tready[gnt]. On transfer:
  - output register loads tdata slice gnt, tuser = gnt, tvalid = 1;
  - beats decrements.
- Output handshake: if M_AXIS_tvalid && M_AXIS_tready and there is no new transfer, tvalid drops to 0. While tvalid && !tready, tdata/tuser/tvalid are held stable.
- Release GRANT → IDLE on any of:
  - a transfer with beats == 1;
  - a cycle with S_AXIS_tready[gnt] = 1 and S_AXIS_tvalid[gnt] = 0 (source starved);
  - ch_enable[gnt] = 0. This takes effect that cycle: tready[gnt] is forced to 0 and no transfer occurs.
- log_burst and ch_enable changes never corrupt a burst in flight. log_burst only takes effect at the next grant.
- A single enabled channel re-wins every arbitration, giving back-to-back bursts separated by the IDLE cycle.

## Timing
- Reset values: state = IDLE, last = NUM_CH-1 (channel 0 wins first), gnt = 0, beats = 0, M_AXIS_tvalid = 0, M_AXIS_tdata = 0, M_AXIS_tuser = 0, S_AXIS_tready = 0.
- Reset mid-burst: the output beat is dropped (tvalid = 0 the next cycle). The source beat presented in the reset cycle is not accepted.
- Grant latency: a request visible in IDLE at cycle n gives tready at n+1. The first beat can appear on M at n+2.
- Data latency: a transfer at cycle k appears on M_AXIS at k+1.
- Full throughput within a burst (1 beat/cycle) while M_AXIS_tready = 1.
- Burst boundary: exactly one IDLE cycle between consecutive grants, so upstream tready has a one-cycle gap per burst.
- log_burst ≥ 16 is clamped to 65536 beats. log_burst = 0 gives 1 beat per grant.

## Configuration
- AXIS_RR_ARBITER_TLAST_EN:
  - Defined: adds output port M_AXIS_tlast (1 bit, reset 0). It is registered alongside tdata, is high on the beat that completes a burst (beats == 1 at transfer), and is also high on the last beat before a starvation or disable release. That last-beat flag is asserted retroactively only if that beat is still held unaccepted in the output register; otherwise no tlast is emitted for that release.
  - Undefined: no tlast port and no tlast logic. Bursts are delimited only by tuser changes.

## Test plan
- Reset, then ch_enable = 4'b0001, log_burst = 2, ch0 valid continuously with tdata 2,3,4,… and M_AXIS_tready = 1 → M shows 2,3,4,5 with tuser = 0, then one-cycle tready gap, then 6,7,8,9.
- All 4 channels enabled and valid, log_burst = 1 → tuser sequence 0,0,1,1,2,2,3,3,0,0, and each source sees exactly 2 tready cycles per round.
- ch1 only, log_burst = 3, M_AXIS_tready low for 5 cycles mid-burst → tdata/tuser stay stable, S_AXIS_tready[1] stays 0 while the output is full, no beat is lost or duplicated, and 8 beats total reach M.
- ch0 granted with log_burst = 4; clear ch_enable[0] after 3 beats → tready[0] drops in the same cycle, ch2 (valid) is granted 2 cycles later, and ch0 is never regranted while disabled.
- areset asserted for 1 cycle mid-burst with the output stalled → next cycle M_AXIS_tvalid = 0, S_AXIS_tready = 0, and ch0 wins first after reset.
- With AXIS_RR_ARBITER_TLAST_EN, log_burst = 2 → M_AXIS_tlast high on every 4th beat only.
